// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard front end: sync + glitch filter, 11-bit frame receiver, arrow/Enter make decoder.
// Define AUTOREPEAT_EN to pulse on every make (typematic repeats); otherwise repeats wait for the break code.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_sys,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic [7:0] key_code,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [4:0]    hit;            // {enter, right, left, down, up}
  logic [4:0]    pulse_q, pulse_d;

  // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    fall   = 1'b0;
    if (clk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
      filt_d = ~filt_q;
      fcnt_d = '0;
      fall   = filt_q;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    key_code_d   = key_code_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    wdog_d       = (state_q == ST_IDLE) ? '0 : wdog_q + 1'b1;
    if (fall) begin
      wdog_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        default: begin
          if (dat_s2_q && ((^shift_q) ^ par_q)) begin
            key_code_d   = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && wdog_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      wdog_d      = '0;
    end
  end

  // Classify the byte presented in the byte_valid cycle; prefixes only set flags.
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    hit   = 5'b0;
    if (byte_valid_q) begin
      if (key_code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (key_code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        hit[0] = ext_q && key_code_q == 8'h75;
        hit[1] = ext_q && key_code_q == 8'h72;
        hit[2] = ext_q && key_code_q == 8'h6B;
        hit[3] = ext_q && key_code_q == 8'h74;
        hit[4] = key_code_q == 8'h5A;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end
  end

`ifdef AUTOREPEAT_EN
  assign pulse_d = brk_q ? 5'b0 : hit;
`else
  logic [4:0] held_q, held_d;

  assign pulse_d = brk_q ? 5'b0 : (hit & ~held_q);
  assign held_d  = brk_q ? (held_q & ~hit) : (held_q | hit);

  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) held_q <= 5'b0;
    else          held_q <= held_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      state_q      <= ST_IDLE;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      wdog_q       <= '0;
      key_code_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      pulse_q      <= 5'b0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      wdog_q       <= wdog_d;
      key_code_q   <= key_code_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      pulse_q      <= pulse_d;
    end
  end

  assign up         = pulse_q[0];
  assign down       = pulse_q[1];
  assign left       = pulse_q[2];
  assign right      = pulse_q[3];
  assign enter      = pulse_q[4];
  assign key_code   = key_code_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random frames against a key-event model.
module tb_ps2_key_decoder;

  localparam int HALF = 100;
  localparam int GAP  = 30;

  logic       clk = 1'b0;
  logic       rst_sys = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       up, down, left, right, enter;
  logic [7:0] key_code;
  logic       byte_valid, frame_err;

  ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk), .rst_sys(rst_sys), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up), .down(down), .left(left), .right(right), .enter(enter),
    .key_code(key_code), .byte_valid(byte_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed activity, sampled on the falling clock edge.
  int   ncyc = 0;
  int   pulse_cnt [5];
  int   bv_cnt = 0, fe_cnt = 0;
  int   last_raw_fall = 0, last_bv = 0, bv_lat = 0, ent_lat = 0;
  logic prev_ps2clk = 1'b1;

  always @(negedge clk) begin
    ncyc++;
    if (prev_ps2clk && !ps2_clk) last_raw_fall = ncyc;
    prev_ps2clk = ps2_clk;
    if (byte_valid) begin
      bv_cnt++;
      bv_lat  = ncyc - last_raw_fall;
      last_bv = ncyc;
    end
    if (enter) ent_lat = ncyc - last_bv;
    if (frame_err) fe_cnt++;
    if (up)    pulse_cnt[0]++;
    if (down)  pulse_cnt[1]++;
    if (left)  pulse_cnt[2]++;
    if (right) pulse_cnt[3]++;
    if (enter) pulse_cnt[4]++;
  end

  // Reference model: keyboard key events in terms of scan-code semantics.
  int   exp_pulse [5];
  int   exp_bv = 0, exp_fe = 0;
  int   exp_kc = 0;
  bit   m_ext = 0, m_brk = 0;
  bit   m_held [5];

  function automatic int key_of(input bit ext, input logic [7:0] code);
    if (code == 8'h5A) return 4;
    if (!ext) return -1;
    case (code)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    exp_bv++;
    exp_kc = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = key_of(m_ext, b);
      if (k >= 0) begin
        if (m_brk) m_held[k] = 0;
        else begin
`ifdef AUTOREPEAT_EN
          exp_pulse[k]++;
`else
          if (!m_held[k]) exp_pulse[k]++;
`endif
          m_held[k] = 1;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_reset();
    exp_kc = 0;
    m_ext  = 0;
    m_brk  = 0;
    foreach (m_held[i]) m_held[i] = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic key_frame(input logic [7:0] b);
    send_frame(b, 1'b0);
    model_byte(b);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".up"},    pulse_cnt[0], exp_pulse[0]);
    chk({tag, ".down"},  pulse_cnt[1], exp_pulse[1]);
    chk({tag, ".left"},  pulse_cnt[2], exp_pulse[2]);
    chk({tag, ".right"}, pulse_cnt[3], exp_pulse[3]);
    chk({tag, ".enter"}, pulse_cnt[4], exp_pulse[4]);
    chk({tag, ".bv"},    bv_cnt,       exp_bv);
    chk({tag, ".ferr"},  fe_cnt,       exp_fe);
    chk({tag, ".code"},  int'(key_code), exp_kc);
  endtask

  logic [7:0] pick_tbl [8];

  initial begin
    logic [7:0] b;
    bit         bad;
    foreach (pulse_cnt[i]) pulse_cnt[i] = 0;
    foreach (exp_pulse[i]) exp_pulse[i] = 0;
    foreach (m_held[i])    m_held[i] = 0;
    pick_tbl[0] = 8'hE0; pick_tbl[1] = 8'hF0; pick_tbl[2] = 8'h75; pick_tbl[3] = 8'h72;
    pick_tbl[4] = 8'h6B; pick_tbl[5] = 8'h74; pick_tbl[6] = 8'h5A; pick_tbl[7] = 8'h1C;

    wait_cyc(5);
    #1;
    chk("reset.outs", int'({up, down, left, right, enter, byte_valid, frame_err}), 0);
    chk("reset.code", int'(key_code), 0);
    rst_sys = 1'b1;
    wait_cyc(10);

    // Plain Enter with latency checks
    key_frame(8'h5A);
    check_all("enter");
    chk("enter.bv_lat_ok", int'(bv_lat >= 5 && bv_lat <= 8), 1);
    chk("enter.after_bv", ent_lat, 1);

    // Up make, up break, left make, unmapped byte
    key_frame(8'hE0); key_frame(8'h75);
    key_frame(8'hE0); key_frame(8'hF0); key_frame(8'h75);
    check_all("up");
    key_frame(8'hE0); key_frame(8'h6B);
    key_frame(8'h1C);
    check_all("left");

    // Repeats of right-arrow make, then break and make again
    for (int i = 0; i < 3; i++) begin
      key_frame(8'hE0); key_frame(8'h74);
    end
    check_all("right_rep");
    key_frame(8'hE0); key_frame(8'hF0); key_frame(8'h74);
    key_frame(8'hE0); key_frame(8'h74);
    check_all("right_again");

    // Parity error leaves key_code and flags alone
    send_frame(8'h72, 1'b1);
    exp_fe++;
    check_all("parity");
    key_frame(8'hE0); key_frame(8'h72);
    check_all("down");

    // Abandoned frame: start plus 4 data bits, then silence
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
    ps2_data = 1'b1;
    wait_cyc(2200);
    exp_fe++;
    check_all("timeout");
    key_frame(8'hF0); key_frame(8'h5A);
    key_frame(8'h5A);
    check_all("after_timeout");

    // Short ps2_clk glitches with data low must not start a frame
    ps2_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_cyc(20);
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
    end
    wait_cyc(20);
    ps2_data = 1'b1;
    wait_cyc(20);
    check_all("glitch");

    // Reset in the middle of a frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    @(negedge clk);
    #2;
    rst_sys = 1'b0;
    #1;
    chk("midrst.outs", int'({up, down, left, right, enter, byte_valid, frame_err}), 0);
    chk("midrst.code", int'(key_code), 0);
    model_reset();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    rst_sys = 1'b1;
    wait_cyc(20);
    key_frame(8'h5A);
    check_all("post_reset");

    // Random scan-code traffic with occasional parity errors
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 5) == 0) b = 8'($urandom);
      else b = pick_tbl[$urandom_range(0, 7)];
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, bad);
      if (bad) exp_fe++;
      else model_byte(b);
      check_all($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Keyboard front end of the maze game: receives PS/2 set-2 scan-code frames and produces one-cycle move/confirm pulses.
- Outputs up/down/left/right/enter drive the level-select, movement and game-state logic directly.
- Also exposes each received byte and error strobes for debug/segment display.

Parameters:
- FILTER_LEN, 8, consecutive equal synchronized samples needed before the filtered ps2_clk level changes (2..255).
- TIMEOUT_CYCLES, 100000, clk cycles without a falling edge before a partially received frame is discarded (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- rst_sys  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- up  out  1  one-cycle pulse, up-arrow make
- down  out  1  one-cycle pulse, down-arrow make
- left  out  1  one-cycle pulse, left-arrow make
- right  out  1  one-cycle pulse, right-arrow make
- enter  out  1  one-cycle pulse, Enter or keypad-Enter make
- key_code  out  8  last valid received byte
- byte_valid  out  1  one-cycle strobe, key_code updated
- frame_err  out  1  one-cycle strobe: parity, stop-bit or timeout error

Behaviour:
- Reset: rst_sys=0 asynchronously clears all outputs to 0, all state to IDLE/0, ext/brk flags and the held mask.
- Input conditioning:
  - ps2_clk and ps2_data each pass through 2 flops.
  - The synchronized ps2_clk feeds a counter filter. The filtered level (reset value 1) toggles only after FILTER_LEN consecutive samples differing from it.
  - fall = filtered 1->0 transition, one cycle wide. Synchronized ps2_data is sampled in the fall cycle.
- Frame FSM, odd parity, LSB-first data:
  - IDLE: on fall, sampled bit 0 -> DATA with bit count 0. Sampled bit 1 -> stay in IDLE, no error.
  - DATA: shift 8 bits LSB-first, then go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: on fall, valid only if stop bit = 1 and XOR(data, parity) = 1. Valid -> key_code <= data and byte_valid=1 in the next cycle. Invalid -> frame_err=1 in the next cycle, byte discarded. Either way return to IDLE.
  - Watchdog: while not in IDLE, count cycles since the last fall. At TIMEOUT_CYCLES -> IDLE, frame_err one cycle, partial byte discarded.
- Byte decoder, acts on the byte_valid cycle:
  - 0xE0: set ext.
  - 0xF0: set brk.
  - Any other byte: classify (ext,code), then clear ext and brk.
    - (1,0x75)=up, (1,0x72)=down, (1,0x6B)=left, (1,0x74)=right, (0,0x5A) or (1,0x5A)=enter.
    - Any other code: ignored, but ext/brk are still cleared.
  - brk=1: clear the key's held bit, no pulse.
  - brk=0 (make): pulse the key output in the cycle after byte_valid, exactly one cycle, unless the key is already held (see optional feature). Then set the held bit.
  - Keypad Enter and main Enter share one held bit.
  - Two prefix bytes in sequence (E0 F0) set both flags; order is not checked.
- Latency: stop-bit fall -> byte_valid +1 cycle -> key pulse +1 cycle. At most one key pulse per frame, so pulses never overlap.
- Reset mid-frame: everything is discarded and no pulse is issued.
- frame_err does not change ext/brk or the held mask.

Optional Feature:
- Macro AUTOREPEAT_EN.
- Defined: every make code pulses, including typematic repeats while the key is held, so a held arrow key moves repeatedly. The held mask is not implemented.
- Undefined: a make pulses only if the key's held bit is 0. Repeats are suppressed until the break code.

Test Plan:
- Bench settings: FILTER_LEN=4, TIMEOUT_CYCLES=2000, PS/2 half-period 100 clk.
- Send frame 0x5A: key_code=0x5A, byte_valid 1 cycle, enter high exactly 1 cycle, 2 cycles after the stop-bit fall; other key outputs 0.
- Send E0 75, then E0 F0 75: one up pulse only, held cleared. Then E0 6B: left pulse. Byte 0x1C (not mapped): no pulse.
- Without AUTOREPEAT_EN, send E0 74 three times: exactly 1 right pulse. After E0 F0 74 then E0 74: a second pulse. With the macro defined: 3 pulses from the first three makes.
- Frame 0x72 sent with a wrong parity bit: frame_err 1 cycle, no byte_valid, key_code unchanged. Then E0 72: down pulse.
- Stop clocks after 4 data bits, wait 2000 cycles: frame_err pulse, FSM in IDLE. The next full 0x5A frame decodes to enter.
- 2-cycle glitches on ps2_clk while idle: no state change. Assert rst_sys low mid-frame: all outputs 0 immediately. The next clean frame decodes correctly.
